// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, word-length codes and parity helper for the UART receiver
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4,
      BRK_WAIT = 3'd5
   } rx_state_e;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   // XOR of the low nbits of data; bits above the word length are ignored.
   function automatic logic parity_of(input logic [7:0] data, input logic [3:0] nbits);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < nbits) begin
            p = p ^ data[i];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_frame_sync_ff.sv
// rtl/uart_rx_frame_sync_ff.sv - multi-stage synchroniser for the asynchronous rx line
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampled UART frame receiver producing one push per character
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OSR         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       sp,
   output logic       push,
   output logic [7:0] rdata,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       busy
);

   localparam int TW = $clog2(OSR);

   rx_state_e   state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [3:0]  nbits_q, nbits_d;
   logic        pen_q, pen_d;
   logic        eps_q, eps_d;
   logic        sp_q, sp_d;
   logic [7:0]  data_q, data_d;
   logic        par_q, par_d;
   logic        push_q, push_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        pe_q, pe_d;
   logic        fe_q, fe_d;
   logic        bi_q, bi_d;
   logic        rxs;
   logic        at_mid;
   logic        at_last;
   logic        par_exp;
   logic        stb_unused;

   // Only the first stop bit is checked, so the stop-bit count never changes receive timing.
   assign stb_unused = stb;

   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   assign at_mid  = (tcnt_q == TW'(OSR/2 - 1));
   assign at_last = (tcnt_q == TW'(OSR - 1));

   always_comb begin
      if (sp_q) begin
         par_exp = ~eps_q;
      end else if (eps_q) begin
         par_exp = parity_of(data_q, nbits_q);
      end else begin
         par_exp = ~parity_of(data_q, nbits_q);
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bidx_d  = bidx_q;
      nbits_d = nbits_q;
      pen_d   = pen_q;
      eps_d   = eps_q;
      sp_d    = sp_q;
      data_d  = data_q;
      par_d   = par_q;
      push_d  = 1'b0;
      rdata_d = rdata_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      bi_d    = bi_q;
      if (baud_pulse) begin
         tcnt_d = tcnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               tcnt_d = '0;
               if (!rxs) begin
                  state_d = START;
               end
            end
            START: begin
               if (at_mid) begin
                  tcnt_d = '0;
                  if (!rxs) begin
                     // Frame format is frozen here so LCR writes mid-frame take effect next frame.
                     state_d = DATA;
                     bidx_d  = '0;
                     nbits_d = 4'd5 + {2'b00, wls};
                     pen_d   = pen;
                     eps_d   = eps;
                     sp_d    = sp;
                     data_d  = '0;
                     par_d   = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DATA: begin
               if (at_last) begin
                  data_d[bidx_q] = rxs;
                  bidx_d         = bidx_q + 3'd1;
                  if ({1'b0, bidx_q} == nbits_q - 4'd1) begin
                     state_d = pen_q ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (at_last) begin
                  par_d   = rxs;
                  state_d = STOP;
               end
            end
            STOP: begin
               if (at_last) begin
                  push_d  = 1'b1;
                  rdata_d = data_q;
                  pe_d    = pen_q & (par_q != par_exp);
                  fe_d    = ~rxs;
                  bi_d    = (data_q == 8'h00) & (~pen_q | ~par_q) & ~rxs;
                  tcnt_d  = '0;
                  state_d = rxs ? IDLE : BRK_WAIT;
               end
            end
            BRK_WAIT: begin
               tcnt_d = '0;
               if (rxs) begin
                  state_d = IDLE;
               end
            end
            default: begin
               tcnt_d  = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         bidx_q  <= '0;
         nbits_q <= '0;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         sp_q    <= 1'b0;
         data_q  <= '0;
         par_q   <= 1'b0;
         push_q  <= 1'b0;
         rdata_q <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         bi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         nbits_q <= nbits_d;
         pen_q   <= pen_d;
         eps_q   <= eps_d;
         sp_q    <= sp_d;
         data_q  <= data_d;
         par_q   <= par_d;
         push_q  <= push_d;
         rdata_q <= rdata_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         bi_q    <= bi_d;
      end
   end

   assign push  = push_q;
   assign rdata = rdata_q;
   assign pe    = pe_q;
   assign fe    = fe_q;
   assign bi    = bi_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_pulse;
   logic       rx;
   logic [1:0] wls;
   logic       stb;
   logic       pen;
   logic       eps;
   logic       sp;
   logic       push;
   logic [7:0] rdata;
   logic       pe;
   logic       fe;
   logic       bi;
   logic       busy;

   logic [1:0] div_q = 2'd0;
   int         cyc = 0;
   int         push_cnt = 0;
   int         push_cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         p0;
   int         c0;

   always #5 clk = ~clk;

   // One baud tick every four clocks: 16 ticks/bit = 64 clocks per bit.
   always @(posedge clk) begin
      div_q <= div_q + 2'd1;
      cyc   <= cyc + 1;
   end
   assign baud_pulse = (div_q == 2'd3);

   always @(negedge clk) begin
      if (push) begin
         push_cnt = push_cnt + 1;
         push_cyc = cyc;
      end
   end

   uart_rx_frame dut (
      .clk        (clk),
      .rst        (rst),
      .baud_pulse (baud_pulse),
      .rx         (rx),
      .wls        (wls),
      .stb        (stb),
      .pen        (pen),
      .eps        (eps),
      .sp         (sp),
      .push       (push),
      .rdata      (rdata),
      .pe         (pe),
      .fe         (fe),
      .bi         (bi),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n * 4) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic use_par,
                             input logic parbit, input logic stopbit);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) begin
         send_bit(d[i]);
      end
      if (use_par) begin
         send_bit(parbit);
      end
      send_bit(stopbit);
      rx = 1'b1;
      ticks(8);
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      wls = 2'b11;
      stb = 1'b0;
      pen = 1'b0;
      eps = 1'b0;
      sp  = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_push", {31'd0, push}, 32'd0);
      check("rst_rdata", {24'd0, rdata}, 32'd0);
      check("rst_pe", {31'd0, pe}, 32'd0);
      check("rst_fe", {31'd0, fe}, 32'd0);
      check("rst_bi", {31'd0, bi}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      ticks(4);

      // 8N1 0xA5 with arrival latency
      p0 = push_cnt;
      c0 = cyc;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      check("a5_pushes", push_cnt - p0, 1);
      check("a5_rdata", {24'd0, rdata}, 32'hA5);
      check("a5_pe", {31'd0, pe}, 32'd0);
      check("a5_fe", {31'd0, fe}, 32'd0);
      check("a5_bi", {31'd0, bi}, 32'd0);
      check("a5_latency_ok", {31'd0, (push_cyc - c0 >= 611) && (push_cyc - c0 <= 614)}, 32'd1);
      check("a5_busy_after", {31'd0, busy}, 32'd0);

      // 5-bit odd parity
      wls = 2'b00;
      pen = 1'b1;
      eps = 1'b0;
      p0  = push_cnt;
      send_frame(8'h10, 5, 1'b1, 1'b0, 1'b1);
      check("odd5_p0_pushes", push_cnt - p0, 1);
      check("odd5_p0_rdata", {24'd0, rdata}, 32'h10);
      check("odd5_p0_pe", {31'd0, pe}, 32'd0);
      send_frame(8'h10, 5, 1'b1, 1'b1, 1'b1);
      check("odd5_p1_rdata", {24'd0, rdata}, 32'h10);
      check("odd5_p1_pe", {31'd0, pe}, 32'd1);

      // Stick parity: sp=1, eps=1 expects a 0 parity bit
      wls = 2'b11;
      sp  = 1'b1;
      eps = 1'b1;
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1);
      check("stick_p1_rdata", {24'd0, rdata}, 32'h3C);
      check("stick_p1_pe", {31'd0, pe}, 32'd1);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1);
      check("stick_p0_pe", {31'd0, pe}, 32'd0);

      // Framing error then a clean frame
      sp  = 1'b0;
      eps = 1'b0;
      pen = 1'b0;
      p0  = push_cnt;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
      check("fe_pushes", push_cnt - p0, 1);
      check("fe_rdata", {24'd0, rdata}, 32'h55);
      check("fe_fe", {31'd0, fe}, 32'd1);
      check("fe_bi", {31'd0, bi}, 32'd0);
      ticks(8);
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
      check("after_fe_pushes", push_cnt - p0, 2);
      check("after_fe_rdata", {24'd0, rdata}, 32'h12);
      check("after_fe_fe", {31'd0, fe}, 32'd0);

      // Break: held low for three frame times
      p0 = push_cnt;
      rx = 1'b0;
      ticks(470);
      check("brk_busy_low", {31'd0, busy}, 32'd1);
      check("brk_pushes_low", push_cnt - p0, 1);
      ticks(10);
      rx = 1'b1;
      ticks(8);
      check("brk_busy_high", {31'd0, busy}, 32'd0);
      check("brk_pushes", push_cnt - p0, 1);
      check("brk_rdata", {24'd0, rdata}, 32'h00);
      check("brk_fe", {31'd0, fe}, 32'd1);
      check("brk_bi", {31'd0, bi}, 32'd1);

      // Glitch: low for 4 ticks only
      p0 = push_cnt;
      rx = 1'b0;
      ticks(4);
      rx = 1'b1;
      ticks(2);
      check("glitch_busy_mid", {31'd0, busy}, 32'd1);
      ticks(16);
      check("glitch_busy_end", {31'd0, busy}, 32'd0);
      check("glitch_pushes", push_cnt - p0, 0);

      // Reset in the middle of the data bits of 0xFF
      p0 = push_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_rdata", {24'd0, rdata}, 32'd0);
      rx  = 1'b1;
      rst = 1'b0;
      ticks(100);
      check("rstmid_pushes", push_cnt - p0, 0);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
      check("post_rst_pushes", push_cnt - p0, 1);
      check("post_rst_rdata", {24'd0, rdata}, 32'h81);
      check("post_rst_fe", {31'd0, fe}, 32'd0);
      check("post_rst_bi", {31'd0, bi}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive stage of the UART, directly upstream of the receive FIFO and the RBR/LSR register read path.
- Mirrors the transmitter. It consumes the raw rx line and the 16x oversample baud_pulse from the divisor-latch baud generator (DLL/DLM).
- It decodes one character per frame using the LCR word-length, stop and parity settings.
- It emits a one-cycle push carrying data plus parity, framing and break status.

Parameters:
- OSR, 16, oversample ticks per bit; must be a power of two, minimum 8.
- SYNC_STAGES, 2, flops in the rx input synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- baud_pulse  in  1  one-clk-wide strobe at OSR x bit rate
- rx  in  1  asynchronous serial input, idle high
- wls  in  2  LCR[1:0] word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  in  1  LCR[2] stop bits; the receiver checks only the first stop bit
- pen  in  1  LCR[3] parity enable
- eps  in  1  LCR[4] even parity select
- sp  in  1  LCR[5] stick parity
- push  out  1  one-cycle strobe: character ready for the FIFO
- rdata  out  8  received character, LSB-aligned, unused upper bits 0
- pe  out  1  parity error, valid with push
- fe  out  1  framing error, valid with push
- bi  out  1  break indication, valid with push
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - push, rdata, pe, fe, bi and busy all go to 0.
  - Synchroniser flops go to 1; state goes to IDLE; tick and bit counters go to 0.
- rx passes through SYNC_STAGES flops. Call the synchronised line rxs. Latency from rx to rxs is SYNC_STAGES clk.
- All state and counter updates occur only on clk edges where baud_pulse=1, except that push self-clears the following clk.
- Tick counter tcnt: log2(OSR) bits, wraps at OSR-1 to 0. The mid-bit sample point is tcnt == OSR/2-1.
- Bit count: nbits = 5 + wls, sampled at the start-bit validation instant. LCR changes mid-frame do not affect the current frame.
- States:
  - IDLE: on a tick with rxs=0, go to START with tcnt=0.
  - START: count ticks. At the mid-bit sample point, rxs=0 means the start is valid; go to DATA with tcnt=0 and bit index=0. rxs=1 means a glitch; return to IDLE with no push.
  - DATA: at each tcnt wrap-to-mid (every OSR ticks after validation), shift rxs into rdata bit[index], LSB first. After nbits samples, go to PARITY if pen=1, else to STOP.
  - PARITY: sample the parity bit one bit-period later. The expected value is chosen in this order:
    - sp=1: expected = ~eps.
    - else eps=1 (even): expected = XOR of the data bits.
    - else (odd): expected = ~XOR of the data bits.
    - pe = (sample != expected).
  - STOP: sample one bit-period later. fe = ~rxs. bi = (data==0) & (parity sample==0 or pen=0) & (rxs==0). Assert push for exactly one clk on the same clk edge the stop is sampled. Then go to IDLE if rxs=1, else to BRK_WAIT.
  - BRK_WAIT: stay until a tick with rxs=1, then go to IDLE. No push while waiting. This makes a held-low line produce exactly one break character.
- rdata, pe, fe and bi hold their values until the next push. They are updated in the same cycle that push rises.
- The next frame's start can be detected on the first tick after returning to IDLE, allowing back-to-back frames with 1 stop bit.
- rst mid-frame aborts the frame immediately: no push, no partial data.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), a 3-bit encoding;
  - constants for the word-length decode (WLS_5..WLS_8);
  - a function parity_of(data, nbits).
- One natural sub-module, sync_ff: SYNC_STAGES-deep synchroniser with parameterised reset value 1. The rest is flat RTL.

Test Plan:
- 8N1 (wls=11, pen=0), rx frame 0xA5 at 16 ticks/bit -> a single push with rdata=0xA5, pe=fe=bi=0, arriving 9.5 bit-periods after the start edge plus sync latency.
- 5-bit odd parity (wls=00, pen=1, eps=0), data 10000, parity bit 0 -> rdata=0x10, pe=0. Same frame with parity bit 1 -> rdata=0x10, pe=1.
- Stick parity (sp=1, eps=1, pen=1, 8-bit), parity bit 1 on data 0x3C -> pe=1. Parity bit 0 -> pe=0.
- Framing error: 8N1 0x55 with stop bit 0, then line high -> push with rdata=0x55, fe=1, bi=0. Next frame 0x12 received normally.
- Break: rx held low for 3 frame times, then high -> exactly one push with rdata=0x00, fe=1, bi=1. busy stays 1 until rx returns high.
- Glitch and reset:
  - rx low for 4 ticks -> no push, busy returns to 0.
  - rst asserted mid-DATA of 0xFF -> no push; the following clean frame 0x81 is received correctly.
